// File: rtl/glitch_pulse_gen.sv
// glitch_pulse_gen: single-shot fault-injection pulse generator.
// Once armed, waits for a synchronised rising edge on trigger, counts the
// latched delay, then drives glitch_out for the latched width. Losing PLL
// lock while not idle aborts immediately and returns to IDLE without done.
module glitch_pulse_gen #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               locked,
  input  logic               trigger,
  input  logic               arm,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] width,
  output logic               glitch_out,
  output logic               armed,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_PULSE
  } state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic               rise;
  logic [DELAY_W-1:0] delay_q;
  logic [WIDTH_W-1:0] width_q;
  logic [DELAY_W-1:0] dcnt;
  logic [WIDTH_W-1:0] pcnt;

  // Three-flop trigger synchroniser plus edge history; runs in every state.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= trigger;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A new 0->1 transition of the synchronised trigger; a level held high
  // across arming never produces it.
  assign rise = s2 & ~s3;

  // Control FSM with registered outputs; lock loss outside IDLE aborts.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      delay_q    <= '0;
      width_q    <= '0;
      dcnt       <= '0;
      pcnt       <= '0;
      glitch_out <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && !locked) begin
        // Abort: truncate any pulse in progress and suppress done.
        state      <= S_IDLE;
        glitch_out <= 1'b0;
        armed      <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (arm && locked) begin
              delay_q <= delay;
              width_q <= width;
              armed   <= 1'b1;
              state   <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (rise) begin
              armed <= 1'b0;
              if (delay_q != '0) begin
                dcnt  <= delay_q - DELAY_W'(1);
                busy  <= 1'b1;
                state <= S_DELAY;
              end else if (width_q != '0) begin
                pcnt       <= width_q - WIDTH_W'(1);
                glitch_out <= 1'b1;
                busy       <= 1'b1;
                state      <= S_PULSE;
              end else begin
                done  <= 1'b1;
                state <= S_IDLE;
              end
            end
          end
          S_DELAY: begin
            if (dcnt != '0) begin
              dcnt <= dcnt - DELAY_W'(1);
            end else if (width_q != '0) begin
              pcnt       <= width_q - WIDTH_W'(1);
              glitch_out <= 1'b1;
              state      <= S_PULSE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_PULSE: begin
            if (pcnt != '0) begin
              pcnt <= pcnt - WIDTH_W'(1);
            end else begin
              glitch_out <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
